shift_rx8: RTL and testbench

- Serial-in/parallel-out receiver; the counterpart of the 8-bit shifter's shift-out path.
- Collects a framed 1-bit stream into a WIDTH-bit word and presents it on a valid/ready output port.
- Has a single-entry holding register, sticky overrun and framing error flags, and a frame-progress counter.
- Sits between a bit-serial link or shifter output and a parallel datapath consumer.

---
 rtl/shift_rx_pkg.sv | 26 ++
 rtl/shift_rx8_if.sv | 25 ++
 rtl/rx_hold_reg.sv | 40 ++++
 rtl/shift_rx8.sv | 137 +++++++++++++
 tb/tb_shift_rx8.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_rx_pkg.sv
// shift_rx8 shared types, state encoding and parity helper.
// SHIFT_RX8_PARITY_EN adds the parity CHECK state.
package shift_rx_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
`ifdef SHIFT_RX8_PARITY_EN
    S_CHECK = ST_CHECK,
`endif
    S_SHIFT = ST_SHIFT
  } state_t;

  // even parity bit over a zero-extended word
  function automatic logic parity(
    input logic [15:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/shift_rx8_if.sv
// Parallel word output port of shift_rx8.
// Master drives the word, slave consumes it.
interface shift_rx8_if
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;

  modport master (
    output o_valid,
    output o_data,
    input  o_ready
  );

  modport slave (
    input  o_valid,
    input  o_data,
    output o_ready
  );

endinterface

// File: rtl/rx_hold_reg.sv
// Single-entry valid/ready holding register.
// Flags an overrun when a push meets a full, unpopped entry.
module rx_hold_reg
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ovr,
  shift_rx8_if.master      o
);

  logic             valid;
  logic [WIDTH-1:0] data;
  logic             pop;
  logic             load;

  assign pop  = valid & o.o_ready;
  assign load = push & (~valid | pop);
  assign ovr  = push & valid & ~o.o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  assign o.o_valid = valid;
  assign o.o_data  = data;

endmodule

// File: rtl/shift_rx8.sv
// Framed serial-in/parallel-out receiver with holding register.
// SHIFT_RX8_PARITY_EN enables a trailing even-parity bit.
module shift_rx8
  import shift_rx_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH+1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sof,
  input  logic          bit_en,
  input  logic          bit_in,
  input  logic          err_clr,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          err_ovr,
  output logic          err_frm,
  shift_rx8_if.master   o
);

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] sr_first;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] push_data;
  logic [CW-1:0]    cnt_n;
  logic             push;
  logic             frm_set;
  logic             ovr;
  logic             last;

  assign sr_first = LSB_FIRST
    ? {bit_in, {(WIDTH-1){1'b0}}}
    : {{(WIDTH-1){1'b0}}, bit_in};
  assign sr_shift = LSB_FIRST
    ? {bit_in, sr[WIDTH-1:1]}
    : {sr[WIDTH-2:0], bit_in};
  assign last = bit_cnt == CW'(WIDTH-1);

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = bit_cnt;
    push      = 1'b0;
    push_data = sr_shift;
    frm_set   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bit_en & sof) begin
          sr_n    = sr_first;
          cnt_n   = CW'(1);
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        unique case (1'b1)
          (bit_en & sof): begin
            frm_set = 1'b1;
            sr_n    = sr_first;
            cnt_n   = CW'(1);
          end
          (bit_en & ~sof & last): begin
            sr_n = sr_shift;
`ifdef SHIFT_RX8_PARITY_EN
            cnt_n   = CW'(WIDTH);
            state_n = S_CHECK;
`else
            push    = 1'b1;
            cnt_n   = '0;
            state_n = S_IDLE;
`endif
          end
          (bit_en & ~sof & ~last): begin
            sr_n  = sr_shift;
            cnt_n = bit_cnt + CW'(1);
          end
          default: ;
        endcase
      end
`ifdef SHIFT_RX8_PARITY_EN
      S_CHECK: begin
        push_data = sr;
        if (bit_en & sof) begin
          frm_set = 1'b1;
          sr_n    = sr_first;
          cnt_n   = CW'(1);
          state_n = S_SHIFT;
        end else if (bit_en) begin
          // parity bit makes the total count of ones even
          if (parity(16'(sr)) == bit_in)
            push = 1'b1;
          else
            frm_set = 1'b1;
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      err_ovr <= 1'b0;
      err_frm <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= cnt_n;
      err_ovr <= ovr | (err_ovr & ~err_clr);
      err_frm <= frm_set | (err_frm & ~err_clr);
    end
  end

  assign busy = state != S_IDLE;

  rx_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (push_data),
    .ovr       (ovr),
    .o         (o)
  );

endmodule

// File: tb/tb_shift_rx8.sv
// Directed testbench for shift_rx8 (LSB-first and MSB-first).
// Define SHIFT_RX8_PARITY_EN to cover the parity bit.
module tb_shift_rx8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sof = 1'b0;
  logic       bit_en = 1'b0;
  logic       bit_in = 1'b0;
  logic       o_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic       busy_a, busy_b;
  logic [3:0] cnt_a, cnt_b;
  logic       ovr_a, ovr_b;
  logic       frm_a, frm_b;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_rx8_if #(.WIDTH(8)) ifa ();
  shift_rx8_if #(.WIDTH(8)) ifb ();

  assign ifa.o_ready = o_ready;
  assign ifb.o_ready = o_ready;

  shift_rx8 #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk     (clk),
    .reset_n (reset_n),
    .sof     (sof),
    .bit_en  (bit_en),
    .bit_in  (bit_in),
    .err_clr (err_clr),
    .busy    (busy_a),
    .bit_cnt (cnt_a),
    .err_ovr (ovr_a),
    .err_frm (frm_a),
    .o       (ifa)
  );

  shift_rx8 #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk     (clk),
    .reset_n (reset_n),
    .sof     (sof),
    .bit_en  (bit_en),
    .bit_in  (bit_in),
    .err_clr (err_clr),
    .busy    (busy_b),
    .bit_cnt (cnt_b),
    .err_ovr (ovr_b),
    .err_frm (frm_b),
    .o       (ifb)
  );

  task automatic drive_bit(input logic s, input logic b);
    sof = s;
    bit_en = 1'b1;
    bit_in = b;
    @(posedge clk);
    #1;
    sof = 1'b0;
    bit_en = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++)
      drive_bit(i == 0, d[i]);
`ifdef SHIFT_RX8_PARITY_EN
    drive_bit(1'b0, ^d);
`endif
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifa.o_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid got %b want 0", ifa.o_valid);
    end
    checks++;
    if (ifa.o_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_data got %h want 00", ifa.o_data);
    end
    checks++;
    if ({busy_a, cnt_a, ovr_a, frm_a} !== 7'd0) begin
      errs++;
      $display("FAIL reset_status got busy=%b cnt=%0d ovr=%b frm=%b want 0",
               busy_a, cnt_a, ovr_a, frm_a);
    end
    reset_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'hAC;
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_bit(i == 0, d[i]);
      if (i == 0) begin
        checks++;
        if ({busy_a, cnt_a} !== {1'b1, 4'd1}) begin
          errs++;
          $display("FAIL first_bit got busy=%b cnt=%0d want 1 1",
                   busy_a, cnt_a);
        end
      end
      if (i == 3) begin
        checks++;
        if (cnt_a !== 4'd4) begin
          errs++;
          $display("FAIL cnt_mid got %0d want 4", cnt_a);
        end
      end
      if (i == 6) begin
        checks++;
        if (ifa.o_valid !== 1'b0) begin
          errs++;
          $display("FAIL early_valid got %b want 0", ifa.o_valid);
        end
      end
    end
`ifdef SHIFT_RX8_PARITY_EN
    checks++;
    if ({busy_a, cnt_a, ifa.o_valid} !== {1'b1, 4'd8, 1'b0}) begin
      errs++;
      $display("FAIL check_state got busy=%b cnt=%0d v=%b want 1 8 0",
               busy_a, cnt_a, ifa.o_valid);
    end
    drive_bit(1'b0, 1'b0);
`endif
    checks++;
    if (ifa.o_valid !== 1'b1) begin
      errs++;
      $display("FAIL done_valid got %b want 1", ifa.o_valid);
    end
    checks++;
    if (ifa.o_data !== 8'hAC) begin
      errs++;
      $display("FAIL lsb_data got %h want ac", ifa.o_data);
    end
    checks++;
    if (ifb.o_data !== 8'h35) begin
      errs++;
      $display("FAIL msb_data got %h want 35", ifb.o_data);
    end
    checks++;
    if ({busy_a, cnt_a, ovr_a, frm_a} !== 7'd0) begin
      errs++;
      $display("FAIL done_status got busy=%b cnt=%0d ovr=%b frm=%b want 0",
               busy_a, cnt_a, ovr_a, frm_a);
    end
    idle_cycle();
    checks++;
    if (ifa.o_valid !== 1'b0) begin
      errs++;
      $display("FAIL valid_pulse got %b want 0", ifa.o_valid);
    end
  endtask

  task automatic test_overrun();
    o_ready = 1'b0;
    send_frame(8'hAC);
    checks++;
    if ({ifa.o_valid, ifa.o_data} !== {1'b1, 8'hAC}) begin
      errs++;
      $display("FAIL ovr_first got v=%b d=%h want 1 ac",
               ifa.o_valid, ifa.o_data);
    end
    repeat (2) idle_cycle();
    checks++;
    if ({ifa.o_valid, ifa.o_data} !== {1'b1, 8'hAC}) begin
      errs++;
      $display("FAIL stall_hold got v=%b d=%h want 1 ac",
               ifa.o_valid, ifa.o_data);
    end
    send_frame(8'h5A);
    checks++;
    if (ifa.o_data !== 8'hAC) begin
      errs++;
      $display("FAIL ovr_keep got %h want ac", ifa.o_data);
    end
    checks++;
    if ({ovr_a, frm_a} !== 2'b10) begin
      errs++;
      $display("FAIL ovr_flag got ovr=%b frm=%b want 1 0", ovr_a, frm_a);
    end
    idle_cycle();
    checks++;
    if (ovr_a !== 1'b1) begin
      errs++;
      $display("FAIL ovr_sticky got %b want 1", ovr_a);
    end
    err_clr = 1'b1;
    idle_cycle();
    err_clr = 1'b0;
    checks++;
    if (ovr_a !== 1'b0) begin
      errs++;
      $display("FAIL ovr_clear got %b want 0", ovr_a);
    end
    o_ready = 1'b1;
    idle_cycle();
    checks++;
    if (ifa.o_valid !== 1'b0) begin
      errs++;
      $display("FAIL ovr_drain got %b want 0", ifa.o_valid);
    end
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b1;
    send_frame(8'h0F);
    checks++;
    if ({ifa.o_valid, ifa.o_data} !== {1'b1, 8'h0F}) begin
      errs++;
      $display("FAIL b2b_first got v=%b d=%h want 1 0f",
               ifa.o_valid, ifa.o_data);
    end
    send_frame(8'hF0);
    checks++;
    if ({ifa.o_valid, ifa.o_data} !== {1'b1, 8'hF0}) begin
      errs++;
      $display("FAIL b2b_second got v=%b d=%h want 1 f0",
               ifa.o_valid, ifa.o_data);
    end
    checks++;
    if ({ovr_a, frm_a} !== 2'b00) begin
      errs++;
      $display("FAIL b2b_err got ovr=%b frm=%b want 0 0", ovr_a, frm_a);
    end
    idle_cycle();
  endtask

  task automatic test_framing();
    o_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    checks++;
    if ({frm_a, cnt_a} !== {1'b0, 4'd3}) begin
      errs++;
      $display("FAIL pre_restart got frm=%b cnt=%0d want 0 3", frm_a, cnt_a);
    end
    drive_bit(1'b1, 1'b1);
    checks++;
    if ({frm_a, cnt_a, busy_a} !== {1'b1, 4'd1, 1'b1}) begin
      errs++;
      $display("FAIL restart got frm=%b cnt=%0d busy=%b want 1 1 1",
               frm_a, cnt_a, busy_a);
    end
    for (int i = 1; i < 8; i++)
      drive_bit(1'b0, 1'b1);
`ifdef SHIFT_RX8_PARITY_EN
    drive_bit(1'b0, 1'b0);
`endif
    checks++;
    if ({ifa.o_valid, ifa.o_data} !== {1'b1, 8'hFF}) begin
      errs++;
      $display("FAIL frm_data got v=%b d=%h want 1 ff",
               ifa.o_valid, ifa.o_data);
    end
    checks++;
    if (frm_a !== 1'b1) begin
      errs++;
      $display("FAIL frm_sticky got %b want 1", frm_a);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    o_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, cnt_a, frm_a, ovr_a} !== 7'd0) begin
      errs++;
      $display("FAIL mid_reset got busy=%b cnt=%0d frm=%b ovr=%b want 0",
               busy_a, cnt_a, frm_a, ovr_a);
    end
    checks++;
    if ({ifa.o_valid, ifa.o_data} !== 9'd0) begin
      errs++;
      $display("FAIL mid_reset_out got v=%b d=%h want 0 00",
               ifa.o_valid, ifa.o_data);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h0F);
    checks++;
    if ({ifa.o_valid, ifa.o_data} !== {1'b1, 8'h0F}) begin
      errs++;
      $display("FAIL post_reset got v=%b d=%h want 1 0f",
               ifa.o_valid, ifa.o_data);
    end
    checks++;
    if (ifb.o_data !== 8'hF0) begin
      errs++;
      $display("FAIL post_reset_msb got %h want f0", ifb.o_data);
    end
    idle_cycle();
  endtask

`ifdef SHIFT_RX8_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    d = 8'hAC;
    o_ready = 1'b1;
    err_clr = 1'b1;
    idle_cycle();
    err_clr = 1'b0;
    for (int i = 0; i < 8; i++)
      drive_bit(i == 0, d[i]);
    drive_bit(1'b0, 1'b0);
    checks++;
    if ({ifa.o_valid, ifa.o_data, frm_a} !== {1'b1, 8'hAC, 1'b0}) begin
      errs++;
      $display("FAIL par_ok got v=%b d=%h frm=%b want 1 ac 0",
               ifa.o_valid, ifa.o_data, frm_a);
    end
    idle_cycle();
    for (int i = 0; i < 8; i++)
      drive_bit(i == 0, d[i]);
    drive_bit(1'b0, 1'b1);
    checks++;
    if ({ifa.o_valid, frm_a, busy_a} !== {1'b0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL par_bad got v=%b frm=%b busy=%b want 0 1 0",
               ifa.o_valid, frm_a, busy_a);
    end
    idle_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_framing();
    test_reset_mid();
`ifdef SHIFT_RX8_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
